// File: rtl/tx_fcs_gen_if.sv
// Signal bundle between the TX buffer/transmit controller and the FCS generator.
// The transmit controller drives the master side and tx_fcs_gen sits on the slave side.
interface tx_fcs_gen_if #(
    parameter int FCS_WIDTH  = 16,
    parameter int BUFF_DEPTH = 128
);
    logic                 start_fcs;
    logic [7:0]           frame_size;
    logic [7:0]           data_buff [BUFF_DEPTH];
    logic [7:0]           tx_buff;
    logic                 data_avail;
    logic                 valid_frame;
    logic                 write_fcs;
    logic [7:0]           data;
    logic                 fcs_done;
    logic [FCS_WIDTH-1:0] fcs_value;

    modport master (
        output start_fcs, frame_size, data_buff, tx_buff, data_avail, valid_frame, write_fcs,
        input  data, fcs_done, fcs_value
    );

    modport slave (
        input  start_fcs, frame_size, data_buff, tx_buff, data_avail, valid_frame, write_fcs,
        output data, fcs_done, fcs_value
    );
endinterface

// File: rtl/tx_fcs_gen.sv
// HDLC transmit FCS generator: runs a byte-wide direct CRC over the TX buffer, then
// passes payload bytes and the FCS bytes (most significant byte first) to zero insertion.
module tx_fcs_gen #(
    parameter int                   FCS_WIDTH  = 16,
    parameter logic [FCS_WIDTH-1:0] POLY       = 'h8005,
    parameter logic [FCS_WIDTH-1:0] INIT       = '0,
    parameter logic [FCS_WIDTH-1:0] XOR_OUT    = '0,
    parameter int                   BUFF_DEPTH = 128
) (
    input  logic          clk,
    input  logic          rst_n,
    tx_fcs_gen_if.slave   bus
);
    localparam int NB = FCS_WIDTH / 8;
    localparam int CW = $clog2(BUFF_DEPTH + 1);
    localparam int AW = (BUFF_DEPTH > 1) ? $clog2(BUFF_DEPTH) : 1;
    localparam int IW = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(BUFF_DEPTH);

    typedef enum logic [2:0] {IDLE, CALC, RUN, FCS_OUT, FCS_END} state_t;

    state_t               state, next_state;
    logic [FCS_WIDTH-1:0] crc, next_crc;
    logic [FCS_WIDTH-1:0] fcs_value_r, next_fcs_value;
    logic [CW-1:0]        byte_cnt, next_byte_cnt;
    logic [CW-1:0]        frame_len, next_frame_len;
    logic [IW-1:0]        fcs_idx, next_fcs_idx;
    logic [7:0]           data_r, next_data;
    logic                 fcs_done_r, next_fcs_done;
    logic [7:0]           cur_byte;
    logic [CW-1:0]        size_clamped;

    // Eight MSB-first bit steps of the direct CRC, flattened into one combinational stage.
    function automatic logic [FCS_WIDTH-1:0] crc_step(input logic [FCS_WIDTH-1:0] c,
                                                       input logic [7:0] d);
        logic [FCS_WIDTH-1:0] r;
        r = c;
        for (int b = 7; b >= 0; b--) begin
            r = (r[FCS_WIDTH-1] ^ d[b]) ? ((r << 1) ^ POLY) : (r << 1);
        end
        return r;
    endfunction

    function automatic logic [7:0] fcs_byte(input logic [FCS_WIDTH-1:0] v,
                                            input logic [IW-1:0] idx);
        return v[FCS_WIDTH-1-8*int'(idx) -: 8];
    endfunction

    assign size_clamped = (int'(bus.frame_size) > BUFF_DEPTH) ? DEPTH_C : CW'(bus.frame_size);
    assign cur_byte     = (byte_cnt < DEPTH_C) ? bus.data_buff[byte_cnt[AW-1:0]] : 8'h00;

    assign bus.data      = data_r;
    assign bus.fcs_done  = fcs_done_r;
    assign bus.fcs_value = fcs_value_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            crc         <= INIT;
            fcs_value_r <= '0;
            byte_cnt    <= '0;
            frame_len   <= '0;
            fcs_idx     <= '0;
            data_r      <= '1;
            fcs_done_r  <= 1'b0;
        end else begin
            state       <= next_state;
            crc         <= next_crc;
            fcs_value_r <= next_fcs_value;
            byte_cnt    <= next_byte_cnt;
            frame_len   <= next_frame_len;
            fcs_idx     <= next_fcs_idx;
            data_r      <= next_data;
            fcs_done_r  <= next_fcs_done;
        end
    end

    // CALC spends one extra cycle after the last byte to publish the result, which
    // also covers the empty frame: FCSDone always rises N+1 cycles after StartFCS.
    always_comb begin
        next_state     = state;
        next_crc       = crc;
        next_fcs_value = fcs_value_r;
        next_byte_cnt  = byte_cnt;
        next_frame_len = frame_len;
        next_fcs_idx   = fcs_idx;
        next_data      = data_r;
        next_fcs_done  = fcs_done_r;
        case (state)
            IDLE: begin
                next_data     = '1;
                next_fcs_done = 1'b0;
                next_crc      = INIT;
                if (bus.start_fcs) begin
                    next_state     = CALC;
                    next_frame_len = size_clamped;
                    next_byte_cnt  = '0;
                end
            end
            CALC: begin
                next_data = bus.tx_buff;
                if (byte_cnt == frame_len) begin
                    next_fcs_done  = 1'b1;
                    next_fcs_value = crc ^ XOR_OUT;
                    next_state     = RUN;
                end else begin
                    next_crc      = crc_step(crc, cur_byte);
                    next_byte_cnt = byte_cnt + CW'(1);
                end
            end
            RUN: begin
                if (!bus.valid_frame && !bus.data_avail) begin
                    next_state    = IDLE;
                    next_data     = '1;
                    next_fcs_done = 1'b0;
                end else if (bus.write_fcs) begin
                    next_state   = FCS_OUT;
                    next_fcs_idx = '0;
                    next_data    = fcs_byte(fcs_value_r, IW'(0));
                end else if (bus.data_avail) begin
                    next_data = bus.tx_buff;
                end
            end
            FCS_OUT: begin
                if (!bus.valid_frame) begin
                    next_state    = IDLE;
                    next_data     = '1;
                    next_fcs_done = 1'b0;
                end else if (bus.write_fcs) begin
                    if (int'(fcs_idx) < NB - 1) begin
                        next_fcs_idx = fcs_idx + IW'(1);
                        next_data    = fcs_byte(fcs_value_r, fcs_idx + IW'(1));
                    end else begin
                        // All-zero byte keeps zero insertion from delaying the closing flag.
                        next_data  = '0;
                        next_state = FCS_END;
                    end
                end
            end
            FCS_END: begin
                next_data = '0;
                if (!bus.valid_frame) begin
                    next_state    = IDLE;
                    next_data     = '1;
                    next_fcs_done = 1'b0;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end
endmodule
